// File: rtl/bl_table_ctrl_if.sv
// Bus bundle for the bit-length table controller: symbol input stream,
// even/odd table write ports, table read side and packed header output.
interface bl_table_ctrl_if;
    logic        bl_valid;
    logic        bl_ready;
    logic [7:0]  bl_sym;
    logic [3:0]  bl_len;
    logic        bl_last;

    logic [6:0]  blt_even_waddr;
    logic        blt_even_wr;
    logic [3:0]  blt_even_wdata;
    logic [6:0]  blt_odd_waddr;
    logic        blt_odd_wr;
    logic [3:0]  blt_odd_wdata;

    logic        blt_rd;
    logic [31:0] blt_dout;
    logic        blt_valid;

    logic        hdr_valid;
    logic        hdr_ready;
    logic [31:0] hdr_data;
    logic        hdr_last;

    modport master (
        input  bl_valid, bl_sym, bl_len, bl_last,
        output bl_ready,
        output blt_even_waddr, blt_even_wr, blt_even_wdata,
        output blt_odd_waddr, blt_odd_wr, blt_odd_wdata,
        output blt_rd,
        input  blt_dout, blt_valid,
        output hdr_valid, hdr_data, hdr_last,
        input  hdr_ready
    );

    modport slave (
        output bl_valid, bl_sym, bl_len, bl_last,
        input  bl_ready,
        input  blt_even_waddr, blt_even_wr, blt_even_wdata,
        input  blt_odd_waddr, blt_odd_wr, blt_odd_wdata,
        input  blt_rd,
        output blt_dout, blt_valid,
        input  hdr_valid, hdr_data, hdr_last,
        output hdr_ready
    );
endinterface

// File: rtl/bl_table_ctrl.sv
// Loads 4-bit code lengths into split even/odd tables, then streams the table
// back as 32 packed words through a 2-entry skid FIFO.
module bl_table_ctrl (
    input  logic            clk,
    input  logic            rst,
    bl_table_ctrl_if.master bus,
    output logic            busy
);

    typedef enum logic [1:0] {IDLE, LOAD, GAP, READ} state_t;

    state_t      state_reg, state_next;
    logic        accept;
    logic        read_active;
    logic        in_valid;
    logic        pop;
    logic        last_pop;
    logic        push_mem;
    logic        pop_mem;
    logic [31:0] head_word;
    logic [5:0]  rd_cnt_reg;
    logic [5:0]  out_cnt_reg;
    logic        inflight_reg;
    logic [1:0]  count_reg, count_next;
    logic        wr_ptr_reg;
    logic        rd_ptr_reg;

    always_ff @(posedge clk) begin
        if (rst) state_reg <= IDLE;
        else     state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (accept) state_next = bus.bl_last ? GAP : LOAD;
            LOAD:    if (accept && bus.bl_last) state_next = GAP;
            GAP:     state_next = READ;
            READ:    if (last_pop) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Reads are throttled so buffered plus in-flight words never exceed the FIFO depth.
    always_comb begin
        bus.bl_ready = 1'b0;
        busy         = 1'b1;
        read_active  = 1'b0;
        bus.blt_rd   = 1'b0;
        case (state_reg)
            IDLE: begin
                bus.bl_ready = 1'b1;
                busy         = 1'b0;
            end
            LOAD: bus.bl_ready = 1'b1;
            READ: begin
                read_active = 1'b1;
                bus.blt_rd  = (rd_cnt_reg < 6'd32) &&
                              (({1'b0, count_reg} + {2'b00, inflight_reg}) < 3'd2);
            end
            default: ;
        endcase
    end

    assign accept = bus.bl_valid & bus.bl_ready;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_port
            logic       hit;
            logic       wr_reg;
            logic [6:0] waddr_reg;
            logic [3:0] wdata_reg;

            assign hit = accept && (bus.bl_sym[0] == 1'(gi));

            always_ff @(posedge clk) begin
                if (rst) begin
                    wr_reg    <= 1'b0;
                    waddr_reg <= '0;
                    wdata_reg <= '0;
                end else begin
                    wr_reg <= hit;
                    if (hit) begin
                        waddr_reg <= bus.bl_sym[7:1];
                        wdata_reg <= bus.bl_len;
                    end
                end
            end
        end
    endgenerate

    assign bus.blt_even_wr    = g_port[0].wr_reg;
    assign bus.blt_even_waddr = g_port[0].waddr_reg;
    assign bus.blt_even_wdata = g_port[0].wdata_reg;
    assign bus.blt_odd_wr     = g_port[1].wr_reg;
    assign bus.blt_odd_waddr  = g_port[1].waddr_reg;
    assign bus.blt_odd_wdata  = g_port[1].wdata_reg;

    // An arriving word bypasses the empty FIFO so a steady stream sees no bubbles.
    assign in_valid = bus.blt_valid & read_active;
    assign pop      = bus.hdr_valid & bus.hdr_ready;
    assign last_pop = pop & bus.hdr_last;
    assign push_mem = in_valid & ~((count_reg == 2'd0) & pop);
    assign pop_mem  = pop & (count_reg != 2'd0);

    assign count_next = count_reg + {1'b0, push_mem} - {1'b0, pop_mem};

    generate
        for (gi = 0; gi < 2; gi++) begin : g_fifo
            logic [31:0] word_reg;

            always_ff @(posedge clk) begin
                if (rst)
                    word_reg <= '0;
                else if (push_mem && (wr_ptr_reg == 1'(gi)))
                    word_reg <= bus.blt_dout;
            end
        end
    endgenerate

    always_comb begin
        head_word = 32'd0;
        if (count_reg != 2'd0)
            head_word = rd_ptr_reg ? g_fifo[1].word_reg : g_fifo[0].word_reg;
        else if (in_valid)
            head_word = bus.blt_dout;
    end

    assign bus.hdr_valid = (count_reg != 2'd0) | in_valid;
    assign bus.hdr_data  = head_word;
    assign bus.hdr_last  = bus.hdr_valid & (out_cnt_reg == 6'd31);

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_cnt_reg   <= '0;
            out_cnt_reg  <= '0;
            inflight_reg <= 1'b0;
            count_reg    <= '0;
            wr_ptr_reg   <= 1'b0;
            rd_ptr_reg   <= 1'b0;
        end else begin
            inflight_reg <= bus.blt_rd;
            count_reg    <= count_next;
            if (state_reg == GAP) begin
                rd_cnt_reg  <= '0;
                out_cnt_reg <= '0;
                wr_ptr_reg  <= 1'b0;
                rd_ptr_reg  <= 1'b0;
            end else begin
                if (bus.blt_rd) rd_cnt_reg  <= rd_cnt_reg + 6'd1;
                if (pop)        out_cnt_reg <= out_cnt_reg + 6'd1;
                if (push_mem)   wr_ptr_reg  <= ~wr_ptr_reg;
                if (pop_mem)    rd_ptr_reg  <= ~rd_ptr_reg;
            end
        end
    end

endmodule

// File: tb/tb_bl_table_ctrl.sv
// Directed bench for bl_table_ctrl: an external even/odd table model plus a
// scoreboard of expected header words built from the loaded bit lengths.
module tb_bl_table_ctrl;

    logic clk = 1'b0;
    logic rst;
    logic busy;

    bl_table_ctrl_if bus();

    bl_table_ctrl dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus),
        .busy (busy)
    );

    always #5 clk = ~clk;

    // External table: written by the DUT, read sequentially with 1-cycle latency.
    logic [3:0] tbl_even [128];
    logic [3:0] tbl_odd  [128];
    logic [4:0] tbl_ptr;

    function automatic logic [31:0] tbl_word(input logic [4:0] w);
        logic [31:0] word;
        word = 32'd0;
        for (int j = 0; j < 4; j++)
            word = {word[23:0], tbl_even[{w, 2'(j)}], tbl_odd[{w, 2'(j)}]};
        return word;
    endfunction

    always @(posedge clk) begin
        if (bus.blt_even_wr) tbl_even[bus.blt_even_waddr] <= bus.blt_even_wdata;
        if (bus.blt_odd_wr)  tbl_odd[bus.blt_odd_waddr]   <= bus.blt_odd_wdata;
        if (rst) begin
            tbl_ptr       <= '0;
            bus.blt_valid <= 1'b0;
            bus.blt_dout  <= '0;
        end else begin
            bus.blt_valid <= bus.blt_rd;
            if (bus.blt_rd) begin
                bus.blt_dout <= tbl_word(tbl_ptr);
                tbl_ptr      <= tbl_ptr + 5'd1;
            end
        end
    end

    typedef struct packed {
        logic [31:0] data;
        logic        last;
    } exp_t;

    exp_t       exp_q[$];
    logic [3:0] shadow [256];

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int n_even, n_odd, n_rd, n_pop, pend;
    int first_rd, first_hv, first_pop, last_pop, c0;
    logic [31:0] first_word;
    logic [31:0] prev_data;
    logic        prev_stall;

    logic        s_ready, s_busy, s_hv, s_hl, s_rd, s_ewr, s_owr;
    logic [31:0] s_hd;
    logic [6:0]  s_oaddr;
    logic [3:0]  s_odata;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_stats();
        n_even = 0; n_odd = 0; n_rd = 0; n_pop = 0; pend = 0;
        first_rd = -1; first_hv = -1; first_pop = -1; last_pop = -1;
        first_word = '0; prev_data = '0; prev_stall = 1'b0;
    endtask

    task automatic push_table();
        exp_t e;
        for (int w = 0; w < 32; w++) begin
            e.data = 32'd0;
            for (int j = 0; j < 8; j++)
                e.data = {e.data[27:0], shadow[8*w + j]};
            e.last = (w == 31);
            exp_q.push_back(e);
        end
    endtask

    // One clock cycle: sample outputs at the falling edge, then return just after the next rise.
    task automatic cycle();
        exp_t head;
        @(negedge clk);
        s_ready = bus.bl_ready;   s_busy  = busy;
        s_hv    = bus.hdr_valid;  s_hd    = bus.hdr_data;  s_hl = bus.hdr_last;
        s_rd    = bus.blt_rd;
        s_ewr   = bus.blt_even_wr;
        s_owr   = bus.blt_odd_wr; s_oaddr = bus.blt_odd_waddr; s_odata = bus.blt_odd_wdata;
        if (s_ewr) n_even++;
        if (s_owr) n_odd++;
        if (s_rd) begin
            if (first_rd < 0) first_rd = cyc;
            chk("rd_outstanding", 32'(pend < 2), 32'd1);
            n_rd++;
            pend++;
        end
        if (prev_stall) chk("hdr_hold", s_hd, prev_data);
        if (s_hv) begin
            if (first_hv < 0) first_hv = cyc;
            chk("sb_nonempty", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
                head = exp_q[0];
                chk("hdr_data", s_hd, head.data);
                chk("hdr_last", 32'(s_hl), 32'(head.last));
                if (bus.hdr_ready) begin
                    void'(exp_q.pop_front());
                    $display("[TB] cyc %0d hdr word %0d data %08h last %0b", cyc, n_pop, s_hd, s_hl);
                    if (first_pop < 0) begin
                        first_pop  = cyc;
                        first_word = s_hd;
                    end
                    last_pop = cyc;
                    n_pop++;
                    pend--;
                end
            end
        end else begin
            chk("hdr_last_idle", 32'(s_hl), 32'd0);
        end
        prev_stall = s_hv & ~bus.hdr_ready;
        prev_data  = s_hd;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic send_sym(input logic [7:0] sym, input logic [3:0] len, input logic last);
        bus.bl_valid = 1'b1;
        bus.bl_sym   = sym;
        bus.bl_len   = len;
        bus.bl_last  = last;
        shadow[sym]  = len;
        if (last) begin
            c0 = cyc;
            push_table();
        end
        cycle();
        chk("bl_ready_load", 32'(s_ready), 32'd1);
        bus.bl_valid = 1'b0;
        bus.bl_last  = 1'b0;
    endtask

    task automatic load_full();
        for (int i = 0; i < 256; i++)
            send_sym(8'(i), 4'(i % 16), i == 255);
        $display("[TB] cyc %0d loaded 256 symbols", cyc);
    endtask

    task automatic run_idle(input int budget, input bit toggle);
        int n;
        n = 0;
        do begin
            if (toggle) bus.hdr_ready = ~bus.hdr_ready;
            cycle();
            n++;
        end while (s_busy && n < budget);
        chk("idle_timeout", 32'(s_busy), 32'd0);
        chk("fifo_empty_idle", 32'(s_hv), 32'd0);
        chk("sb_drained", exp_q.size(), 32'd0);
    endtask

    initial begin
        int n;
        rst = 1'b1;
        bus.bl_valid  = 1'b1;
        bus.bl_sym    = 8'h05;
        bus.bl_len    = 4'h3;
        bus.bl_last   = 1'b0;
        bus.hdr_ready = 1'b0;
        clear_stats();
        @(posedge clk);
        #1;

        // Reset with a symbol presented: nothing accepted, outputs at reset values.
        repeat (3) cycle();
        chk("rst_bl_ready", 32'(s_ready), 32'd1);
        chk("rst_busy", 32'(s_busy), 32'd0);
        chk("rst_hdr_valid", 32'(s_hv), 32'd0);
        chk("rst_blt_rd", 32'(s_rd), 32'd0);
        chk("rst_hdr_data", s_hd, 32'd0);
        chk("rst_strobes", 32'(n_even + n_odd), 32'd0);
        rst = 1'b0;
        bus.bl_valid = 1'b0;
        cycle();
        chk("rst_no_write", 32'(s_ewr | s_owr), 32'd0);
        chk("rst_idle", 32'(s_busy), 32'd0);

        // Full in-order load, downstream always ready.
        clear_stats();
        bus.hdr_ready = 1'b1;
        load_full();
        run_idle(200, 1'b0);
        chk("a_even_strobes", n_even, 32'd128);
        chk("a_odd_strobes", n_odd, 32'd128);
        chk("a_words", n_pop, 32'd32);
        chk("a_consecutive", 32'(last_pop - first_pop), 32'd31);
        chk("a_word0", first_word, 32'h01234567);
        chk("a_rd_latency", 32'(first_rd - c0), 32'd2);
        chk("a_hv_latency", 32'(first_hv - c0), 32'd3);

        // Same load, downstream ready toggling every cycle.
        clear_stats();
        load_full();
        run_idle(400, 1'b1);
        chk("b_words", n_pop, 32'd32);
        chk("b_reads", n_rd, 32'd32);

        // Single odd symbol.
        clear_stats();
        bus.hdr_ready = 1'b1;
        send_sym(8'h03, 4'hA, 1'b1);
        cycle();
        chk("c_odd_wr", 32'(s_odd_wr_or(s_owr)), 32'd1);
        chk("c_odd_addr", 32'(s_oaddr), 32'h01);
        chk("c_odd_data", 32'(s_odata), 32'hA);
        chk("c_even_wr", 32'(s_ewr), 32'd0);
        chk("c_gap_ready", 32'(s_ready), 32'd0);
        cycle();
        chk("c_odd_wr_single", 32'(s_owr), 32'd0);
        chk("c_rd_c2", 32'(s_rd), 32'd1);
        run_idle(200, 1'b0);
        chk("c_rd_latency", 32'(first_rd - c0), 32'd2);
        chk("c_hv_latency", 32'(first_hv - c0), 32'd3);
        chk("c_odd_strobes", n_odd, 32'd1);
        chk("c_words", n_pop, 32'd32);

        // Downstream stalled for a long stretch in READ.
        clear_stats();
        bus.hdr_ready = 1'b0;
        send_sym(8'h10, 4'h7, 1'b1);
        repeat (22) cycle();
        chk("d_stall_valid", 32'(s_hv), 32'd1);
        chk("d_stall_reads", n_rd, 32'd2);
        chk("d_stall_pops", n_pop, 32'd0);
        bus.hdr_ready = 1'b1;
        run_idle(200, 1'b0);
        chk("d_words", n_pop, 32'd32);
        chk("d_reads", n_rd, 32'd32);

        // Reset in the middle of the read-out, then a clean reload.
        clear_stats();
        send_sym(8'hFE, 4'h2, 1'b1);
        n = 0;
        while (n_pop < 10 && n < 100) begin
            cycle();
            n++;
        end
        chk("e_reach_10", n_pop, 32'd10);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        cycle();
        chk("e_rst_hdr_valid", 32'(s_hv), 32'd0);
        chk("e_rst_blt_rd", 32'(s_rd), 32'd0);
        chk("e_rst_busy", 32'(s_busy), 32'd0);
        chk("e_rst_bl_ready", 32'(s_ready), 32'd1);
        exp_q.delete();
        clear_stats();
        load_full();
        run_idle(200, 1'b0);
        chk("e_words", n_pop, 32'd32);
        chk("e_word0", first_word, 32'h01234567);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    function automatic logic s_odd_wr_or(input logic v);
        return v;
    endfunction

endmodule
